// File: rtl/dram_pkg.sv
// Shared definitions for the timed DRAM device model.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_pkg;

    // Command codes as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_REF = 4'b0001;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REF  = 1'b1
    } seq_state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_bank_ctrl.sv
// Per-bank state: IDLE/ACTIVE, open row and the ACT/PRE spacing timer.
// Latency: legality outputs are combinational from registered state.
// Backpressure: none; timer freezes while dram_clk_en is low.
// Ports: do_act/do_pre are accepted-command strobes from the decoder;
//        ok_act/ok_rdwr tell the decoder whether ACT or RD/WR is legal now.
module dram_bank_ctrl
    import dram_pkg::*;
#(
    parameter int ROW_WIDTH = 7,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2
) (
    input  logic                 dram_clk,
    input  logic                 dram_rst_n,
    input  logic                 dram_clk_en,
    input  logic                 do_act,
    input  logic                 do_pre,
    input  logic [ROW_WIDTH-1:0] act_row,
    output logic                 ok_act,
    output logic                 ok_rdwr,
    output logic                 bank_active,
    output logic [ROW_WIDTH-1:0] open_row
);

    localparam int TMR_W = $clog2(max(T_RCD, T_RP) + 1);

    bank_state_t      state;
    logic [TMR_W-1:0] timer;

    // Timer is loaded with T-1 so that a command sampled exactly T edges
    // after ACT/PRE sees it at zero.
    always_ff @(posedge dram_clk or negedge dram_rst_n) begin
        if (!dram_rst_n) begin
            state    <= BANK_IDLE;
            timer    <= '0;
            open_row <= '0;
        end else if (do_act) begin
            state    <= BANK_ACTIVE;
            open_row <= act_row;
            timer    <= TMR_W'(T_RCD - 1);
        end else if (do_pre) begin
            state    <= BANK_IDLE;
            timer    <= TMR_W'(T_RP - 1);
        end else if (dram_clk_en && (timer != '0)) begin
            timer    <= timer - 1'b1;
        end
    end

    assign bank_active = (state == BANK_ACTIVE);
    assign ok_act      = (state == BANK_IDLE)   && (timer == '0);
    assign ok_rdwr     = (state == BANK_ACTIVE) && (timer == '0);

endmodule

// File: rtl/dram_timed_model.sv
// Multi-bank DRAM device model: command decode, timing checks, CAS read pipe, refresh.
// Latency: RD data valid CAS_LATENCY-1 edges after the sampling edge; REF done after NUM_ROWS edges.
// Backpressure: none; illegal/early commands pulse dram_cmd_err, dram_clk_en low holds the pipe.
// Ports: command pins {cs_n,ras_n,cas_n,we_n}, dram_addr/dram_bank_id/dram_wr_data in;
//        dram_rd_data/dram_rd_valid, dram_cmd_err, dram_refresh_done, dram_refresh_timeout out.
module dram_timed_model
    import dram_pkg::*;
#(
    parameter int NUM_BANKS        = 8,
    parameter int NUM_ROWS         = 128,
    parameter int ROW_BITS         = 8,
    parameter int DATA_WIDTH       = 2,
    parameter int CAS_LATENCY      = 2,
    parameter int T_RCD            = 2,
    parameter int T_RP             = 2,
    parameter int REFRESH_INTERVAL = 1250,
    localparam int NUM_COLS   = ROW_BITS / DATA_WIDTH,
    localparam int COL_WIDTH  = $clog2(NUM_COLS),
    localparam int ROW_WIDTH  = $clog2(NUM_ROWS),
    localparam int BANK_WIDTH = $clog2(NUM_BANKS),
    localparam int ADDR_WIDTH = max(ROW_WIDTH, COL_WIDTH)
) (
    input  logic                  dram_clk,
    input  logic                  dram_rst_n,
    input  logic                  dram_clk_en,
    input  logic                  dram_cs_n,
    input  logic                  dram_ras_n,
    input  logic                  dram_cas_n,
    input  logic                  dram_we_n,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [BANK_WIDTH-1:0] dram_bank_id,
    input  logic [DATA_WIDTH-1:0] dram_wr_data,
    output logic [DATA_WIDTH-1:0] dram_rd_data,
    output logic                  dram_rd_valid,
    output logic                  dram_cmd_err,
    output logic                  dram_refresh_done,
    output logic                  dram_refresh_timeout
);

    localparam int LSB_W = $clog2(ROW_BITS);
    localparam int RF_W  = $clog2(REFRESH_INTERVAL + 1);

    // Storage: array is flattened {bank,row}; neither it nor the row buffers are reset.
    logic [ROW_BITS-1:0]   mem     [NUM_BANKS*NUM_ROWS];
    logic [ROW_BITS-1:0]   row_buf [NUM_BANKS];

    logic [NUM_BANKS-1:0]  ok_act, ok_rdwr, bank_active;
    logic [ROW_WIDTH-1:0]  open_row [NUM_BANKS];

    logic [3:0]            cmd;
    logic                  acc_act, acc_pre, acc_rd, acc_wr, acc_ref, cmd_rej;
    logic                  col_ok;
    logic [ROW_WIDTH-1:0]  act_row;
    logic [LSB_W-1:0]      col_lsb;
    logic [DATA_WIDTH-1:0] rd_word;

    seq_state_t            seq_state;
    logic [ROW_WIDTH-1:0]  row_ptr;
    logic                  ref_last;
    logic [RF_W-1:0]       rf_cnt;

    logic [CAS_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0]  pipe_dat [CAS_LATENCY];

    assign cmd     = {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n};
    assign act_row = dram_addr[ROW_WIDTH-1:0];
    assign col_ok  = 32'(dram_addr) < 32'(NUM_COLS);
    assign col_lsb = LSB_W'(dram_addr) * LSB_W'(DATA_WIDTH);
    assign rd_word = row_buf[dram_bank_id][col_lsb +: DATA_WIDTH];

    genvar g;
    generate
        for (g = 0; g < NUM_BANKS; g++) begin : g_bank
            dram_bank_ctrl #(
                .ROW_WIDTH (ROW_WIDTH),
                .T_RCD     (T_RCD),
                .T_RP      (T_RP)
            ) u_bank (
                .dram_clk    (dram_clk),
                .dram_rst_n  (dram_rst_n),
                .dram_clk_en (dram_clk_en),
                .do_act      (acc_act && (dram_bank_id == BANK_WIDTH'(g))),
                .do_pre      (acc_pre && (dram_bank_id == BANK_WIDTH'(g))),
                .act_row     (act_row),
                .ok_act      (ok_act[g]),
                .ok_rdwr     (ok_rdwr[g]),
                .bank_active (bank_active[g]),
                .open_row    (open_row[g])
            );
        end
    endgenerate

    // Command decode. PRE to an idle bank is legal but does nothing, so it
    // neither asserts acc_pre nor rejects.
    always_comb begin
        acc_act = 1'b0;
        acc_pre = 1'b0;
        acc_rd  = 1'b0;
        acc_wr  = 1'b0;
        acc_ref = 1'b0;
        cmd_rej = 1'b0;
        if (dram_clk_en && !dram_cs_n) begin
            if (seq_state == S_REF) begin
                cmd_rej = (cmd != CMD_NOP);
            end else begin
                case (cmd)
                    CMD_NOP: ;
                    CMD_PRE: acc_pre = bank_active[dram_bank_id];
                    CMD_ACT: begin
                        acc_act = ok_act[dram_bank_id];
                        cmd_rej = !ok_act[dram_bank_id];
                    end
                    CMD_RD: begin
                        acc_rd  = ok_rdwr[dram_bank_id] && col_ok;
                        cmd_rej = !(ok_rdwr[dram_bank_id] && col_ok);
                    end
                    CMD_WR: begin
                        acc_wr  = ok_rdwr[dram_bank_id] && col_ok;
                        cmd_rej = !(ok_rdwr[dram_bank_id] && col_ok);
                    end
                    CMD_REF: begin
                        acc_ref = &ok_act;
                        cmd_rej = !(&ok_act);
                    end
                    default: cmd_rej = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge dram_clk) begin
        if (acc_act) row_buf[dram_bank_id] <= mem[{dram_bank_id, act_row}];
        if (acc_wr)  row_buf[dram_bank_id][col_lsb +: DATA_WIDTH] <= dram_wr_data;
        if (acc_pre) mem[{dram_bank_id, open_row[dram_bank_id]}] <= row_buf[dram_bank_id];
    end

    // Read pipeline; data is poisoned to all-ones if the refresh deadline
    // has already been missed when the RD is sampled.
    always_ff @(posedge dram_clk or negedge dram_rst_n) begin
        if (!dram_rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < CAS_LATENCY; i++) pipe_dat[i] <= '0;
        end else if (dram_clk_en) begin
            pipe_vld[0] <= acc_rd;
            pipe_dat[0] <= acc_rd ? (dram_refresh_timeout ? '1 : rd_word) : '0;
            for (int i = 1; i < CAS_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign dram_rd_valid = pipe_vld[CAS_LATENCY-1];
    assign dram_rd_data  = pipe_dat[CAS_LATENCY-1];

    // Refresh sequencer only walks the row pointer: contents are static in
    // this model, so a refresh is pure timing.
    assign ref_last = (seq_state == S_REF) && (row_ptr == ROW_WIDTH'(NUM_ROWS - 1));

    always_ff @(posedge dram_clk or negedge dram_rst_n) begin
        if (!dram_rst_n) begin
            seq_state            <= S_IDLE;
            row_ptr              <= '0;
            rf_cnt               <= '0;
            dram_cmd_err         <= 1'b0;
            dram_refresh_done    <= 1'b0;
            dram_refresh_timeout <= 1'b0;
        end else begin
            dram_cmd_err      <= cmd_rej;
            dram_refresh_done <= ref_last;

            if (seq_state == S_IDLE) begin
                if (acc_ref) begin
                    seq_state <= S_REF;
                    row_ptr   <= '0;
                end
            end else if (ref_last) begin
                seq_state <= S_IDLE;
            end else begin
                row_ptr <= row_ptr + 1'b1;
            end

            // A REF landing on the same edge the counter would hit the
            // interval wins: counter clears and timeout stays low.
            if (acc_ref)
                rf_cnt <= '0;
            else if (rf_cnt != RF_W'(REFRESH_INTERVAL))
                rf_cnt <= rf_cnt + 1'b1;

            if (!acc_ref && (rf_cnt >= RF_W'(REFRESH_INTERVAL - 1)))
                dram_refresh_timeout <= 1'b1;
            else if (ref_last)
                dram_refresh_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dram_timed_model.sv
// Directed bench for dram_timed_model with default parameters.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_dram_timed_model;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_REF = 4'b0001;

    logic       dram_clk = 1'b0;
    logic       dram_rst_n;
    logic       dram_clk_en;
    logic       dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
    logic [6:0] dram_addr;
    logic [2:0] dram_bank_id;
    logic [1:0] dram_wr_data;
    logic [1:0] dram_rd_data;
    logic       dram_rd_valid;
    logic       dram_cmd_err;
    logic       dram_refresh_done;
    logic       dram_refresh_timeout;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 dram_clk = ~dram_clk;

    dram_timed_model dut (
        .dram_clk             (dram_clk),
        .dram_rst_n           (dram_rst_n),
        .dram_clk_en          (dram_clk_en),
        .dram_cs_n            (dram_cs_n),
        .dram_ras_n           (dram_ras_n),
        .dram_cas_n           (dram_cas_n),
        .dram_we_n            (dram_we_n),
        .dram_addr            (dram_addr),
        .dram_bank_id         (dram_bank_id),
        .dram_wr_data         (dram_wr_data),
        .dram_rd_data         (dram_rd_data),
        .dram_rd_valid        (dram_rd_valid),
        .dram_cmd_err         (dram_cmd_err),
        .dram_refresh_done    (dram_refresh_done),
        .dram_refresh_timeout (dram_refresh_timeout)
    );

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge dram_clk);
            #1;
        end
    endtask

    // Drive one command for exactly one edge, then return to NOP.
    task automatic issue(input logic [3:0] c, input int b, input int a, input logic [1:0] d);
        {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = c;
        dram_bank_id = 3'(b);
        dram_addr    = 7'(a);
        dram_wr_data = d;
        @(posedge dram_clk);
        #1;
        {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = 4'b1111;
    endtask

    task automatic test_reset;
        dram_rst_n   = 1'b0;
        dram_clk_en  = 1'b1;
        {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = 4'b1111;
        dram_addr    = '0;
        dram_bank_id = '0;
        dram_wr_data = '0;
        #12;
        vec_cnt++;
        if ({dram_rd_valid, dram_rd_data, dram_cmd_err, dram_refresh_done, dram_refresh_timeout} !== 6'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {dram_rd_valid, dram_rd_data, dram_cmd_err, dram_refresh_done, dram_refresh_timeout});
        end
        @(posedge dram_clk);
        #1;
        dram_rst_n = 1'b1;
        idle(2);
        vec_cnt++;
        if ({dram_rd_valid, dram_cmd_err, dram_refresh_done, dram_refresh_timeout} !== 4'b0) begin
            err_cnt++;
            $display("FAIL post_reset_quiet: got %b expected 0000",
                     {dram_rd_valid, dram_cmd_err, dram_refresh_done, dram_refresh_timeout});
        end
    endtask

    task automatic test_basic_rw;
        issue(C_ACT, 3, 5, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b0) begin err_cnt++; $display("FAIL act_accept: err=%b expected 0", dram_cmd_err); end
        idle(1);
        issue(C_WR, 3, 2, 2'b10);
        vec_cnt++;
        if (dram_cmd_err !== 1'b0) begin err_cnt++; $display("FAIL wr_at_trcd: err=%b expected 0", dram_cmd_err); end
        issue(C_RD, 3, 2, 2'b00);
        vec_cnt++;
        if (dram_rd_valid !== 1'b0) begin err_cnt++; $display("FAIL rd_not_early: valid=%b expected 0", dram_rd_valid); end
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b1 || dram_rd_data !== 2'b10) begin
            err_cnt++;
            $display("FAIL rd_cl2_data: valid=%b data=%b expected 1/10", dram_rd_valid, dram_rd_data);
        end
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b0) begin err_cnt++; $display("FAIL rd_one_cycle: valid=%b expected 0", dram_rd_valid); end
    endtask

    task automatic test_clk_en;
        issue(C_RD, 3, 2, 2'b00);
        dram_clk_en = 1'b0;
        // ACT on an already-active bank would be an error, but is a NOP here
        issue(C_ACT, 3, 1, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b0 || dram_rd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL clk_en_nop: err=%b valid=%b expected 0/0", dram_cmd_err, dram_rd_valid);
        end
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b0) begin err_cnt++; $display("FAIL clk_en_hold: valid=%b expected 0", dram_rd_valid); end
        dram_clk_en = 1'b1;
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b1 || dram_rd_data !== 2'b10) begin
            err_cnt++;
            $display("FAIL clk_en_resume: valid=%b data=%b expected 1/10", dram_rd_valid, dram_rd_data);
        end
        idle(1);
    endtask

    task automatic test_trcd;
        issue(C_ACT, 1, 0, 2'b00);
        issue(C_RD, 1, 0, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b1) begin err_cnt++; $display("FAIL trcd_early_err: err=%b expected 1", dram_cmd_err); end
        issue(C_RD, 1, 0, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b0 || dram_rd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL trcd_ok: err=%b valid=%b expected 0/0", dram_cmd_err, dram_rd_valid);
        end
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b1) begin err_cnt++; $display("FAIL trcd_rd_valid: valid=%b expected 1", dram_rd_valid); end
        idle(1);
    endtask

    task automatic test_illegal;
        issue(4'b0110, 3, 0, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b1) begin err_cnt++; $display("FAIL illegal_code: err=%b expected 1", dram_cmd_err); end
        issue(C_RD, 3, 4, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b1) begin err_cnt++; $display("FAIL col_range: err=%b expected 1", dram_cmd_err); end
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b0 || dram_cmd_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL rejected_no_valid: valid=%b err=%b expected 0/0", dram_rd_valid, dram_cmd_err);
        end
    endtask

    task automatic test_persist;
        issue(C_PRE, 3, 0, 2'b00);
        issue(C_ACT, 3, 6, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b1) begin err_cnt++; $display("FAIL trp_early_err: err=%b expected 1", dram_cmd_err); end
        issue(C_ACT, 3, 6, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b0) begin err_cnt++; $display("FAIL trp_ok: err=%b expected 0", dram_cmd_err); end
        idle(1);
        issue(C_WR, 3, 2, 2'b01);
        issue(C_WR, 3, 0, 2'b11);
        issue(C_PRE, 3, 0, 2'b00);
        idle(1);
        issue(C_ACT, 3, 5, 2'b00);
        idle(1);
        issue(C_RD, 3, 2, 2'b00);
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b1 || dram_rd_data !== 2'b10) begin
            err_cnt++;
            $display("FAIL row5_preserved: valid=%b data=%b expected 1/10", dram_rd_valid, dram_rd_data);
        end
        issue(C_PRE, 3, 0, 2'b00);
        idle(1);
        issue(C_ACT, 3, 6, 2'b00);
        idle(1);
        issue(C_RD, 3, 2, 2'b00);
        issue(C_RD, 3, 0, 2'b00);
        vec_cnt++;
        if (dram_rd_valid !== 1'b1 || dram_rd_data !== 2'b01) begin
            err_cnt++;
            $display("FAIL b2b_first: valid=%b data=%b expected 1/01", dram_rd_valid, dram_rd_data);
        end
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b1 || dram_rd_data !== 2'b11) begin
            err_cnt++;
            $display("FAIL b2b_second: valid=%b data=%b expected 1/11", dram_rd_valid, dram_rd_data);
        end
        idle(1);
    endtask

    task automatic test_refresh;
        issue(C_ACT, 0, 0, 2'b00);
        idle(1);
        issue(C_REF, 0, 0, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b1) begin err_cnt++; $display("FAIL ref_bank_open: err=%b expected 1", dram_cmd_err); end
        issue(C_PRE, 0, 0, 2'b00);
        issue(C_PRE, 1, 0, 2'b00);
        issue(C_PRE, 3, 0, 2'b00);
        issue(C_REF, 0, 0, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b1) begin err_cnt++; $display("FAIL ref_trp_early: err=%b expected 1", dram_cmd_err); end
        issue(C_REF, 0, 0, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b0) begin err_cnt++; $display("FAIL ref_accept: err=%b expected 0", dram_cmd_err); end
        issue(C_RD, 0, 0, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b1) begin err_cnt++; $display("FAIL rd_during_ref: err=%b expected 1", dram_cmd_err); end
        idle(126);
        vec_cnt++;
        if (dram_refresh_done !== 1'b0) begin err_cnt++; $display("FAIL ref_done_early: done=%b expected 0", dram_refresh_done); end
        idle(1);
        vec_cnt++;
        if (dram_refresh_done !== 1'b1) begin err_cnt++; $display("FAIL ref_done_128: done=%b expected 1", dram_refresh_done); end
        idle(1);
        vec_cnt++;
        if (dram_refresh_done !== 1'b0) begin err_cnt++; $display("FAIL ref_done_pulse: done=%b expected 0", dram_refresh_done); end
    endtask

    // Anchor REF at edge k; a second REF exactly at k+1250 must pre-empt the timeout.
    task automatic test_ref_race;
        issue(C_REF, 0, 0, 2'b00);
        idle(128);
        vec_cnt++;
        if (dram_refresh_done !== 1'b1) begin err_cnt++; $display("FAIL race_anchor_done: done=%b expected 1", dram_refresh_done); end
        idle(1121);
        vec_cnt++;
        if (dram_refresh_timeout !== 1'b0) begin err_cnt++; $display("FAIL race_pre_timeout: to=%b expected 0", dram_refresh_timeout); end
        issue(C_REF, 0, 0, 2'b00);
        vec_cnt++;
        if (dram_refresh_timeout !== 1'b0 || dram_cmd_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL race_ref_wins: to=%b err=%b expected 0/0", dram_refresh_timeout, dram_cmd_err);
        end
    endtask

    // Continues from the REF issued at the end of test_ref_race (edge k).
    task automatic test_timeout;
        idle(128);
        vec_cnt++;
        if (dram_refresh_done !== 1'b1) begin err_cnt++; $display("FAIL to_anchor_done: done=%b expected 1", dram_refresh_done); end
        issue(C_ACT, 2, 9, 2'b00);
        idle(1);
        issue(C_WR, 2, 0, 2'b01);
        idle(1118);
        vec_cnt++;
        if (dram_refresh_timeout !== 1'b0) begin err_cnt++; $display("FAIL timeout_1249: to=%b expected 0", dram_refresh_timeout); end
        idle(1);
        vec_cnt++;
        if (dram_refresh_timeout !== 1'b1) begin err_cnt++; $display("FAIL timeout_1250: to=%b expected 1", dram_refresh_timeout); end
        issue(C_RD, 2, 0, 2'b00);
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b1 || dram_rd_data !== 2'b11) begin
            err_cnt++;
            $display("FAIL poison_rd: valid=%b data=%b expected 1/11", dram_rd_valid, dram_rd_data);
        end
        issue(C_PRE, 2, 0, 2'b00);
        idle(1);
        issue(C_REF, 0, 0, 2'b00);
        idle(127);
        vec_cnt++;
        if (dram_refresh_timeout !== 1'b1) begin err_cnt++; $display("FAIL timeout_held: to=%b expected 1", dram_refresh_timeout); end
        idle(1);
        vec_cnt++;
        if (dram_refresh_done !== 1'b1 || dram_refresh_timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_clear: done=%b to=%b expected 1/0", dram_refresh_done, dram_refresh_timeout);
        end
        issue(C_ACT, 2, 9, 2'b00);
        idle(1);
        issue(C_RD, 2, 0, 2'b00);
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b1 || dram_rd_data !== 2'b01) begin
            err_cnt++;
            $display("FAIL unpoisoned_rd: valid=%b data=%b expected 1/01", dram_rd_valid, dram_rd_data);
        end
        issue(C_PRE, 2, 0, 2'b00);
        idle(2);
    endtask

    task automatic test_reset_abort;
        int done_seen;
        // Mid-pipeline reset: RD sampled, reset before its data emerges
        issue(C_ACT, 0, 0, 2'b00);
        idle(1);
        issue(C_RD, 0, 0, 2'b00);
        dram_rst_n = 1'b0;
        #1;
        idle(1);
        vec_cnt++;
        if (dram_rd_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_pipe_abort: valid=%b expected 0", dram_rd_valid); end
        dram_rst_n = 1'b1;
        issue(C_REF, 0, 0, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b0) begin err_cnt++; $display("FAIL rst_banks_idle: err=%b expected 0", dram_cmd_err); end
        idle(10);
        dram_rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({dram_rd_valid, dram_rd_data, dram_cmd_err, dram_refresh_done, dram_refresh_timeout} !== 6'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_ref_outputs: got %b expected 000000",
                     {dram_rd_valid, dram_rd_data, dram_cmd_err, dram_refresh_done, dram_refresh_timeout});
        end
        idle(1);
        dram_rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 130; i++) begin
            idle(1);
            if (dram_refresh_done === 1'b1) done_seen++;
        end
        vec_cnt++;
        if (done_seen !== 0) begin err_cnt++; $display("FAIL rst_no_done: pulses=%0d expected 0", done_seen); end
        issue(C_REF, 0, 0, 2'b00);
        vec_cnt++;
        if (dram_cmd_err !== 1'b0) begin err_cnt++; $display("FAIL rst_ref_accept: err=%b expected 0", dram_cmd_err); end
        idle(128);
        vec_cnt++;
        if (dram_refresh_done !== 1'b1) begin err_cnt++; $display("FAIL rst_ref_done: done=%b expected 1", dram_refresh_done); end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_clk_en();
        test_trcd();
        test_illegal();
        test_persist();
        test_refresh();
        test_ref_race();
        test_timeout();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
